// File: rtl/iomem_arbiter_if.sv
// iomem_arbiter_if: requester, memory and status signals of the IOSys memory arbiter.
interface iomem_arbiter_if;
    logic        ram_busy;
    logic        p0_valid, p1_valid, p2_valid;
    logic [22:0] p0_addr, p1_addr, p2_addr;
    logic [31:0] p0_wdata, p1_wdata, p2_wdata;
    logic [3:0]  p0_wstrb, p1_wstrb, p2_wstrb;
    logic        p0_ready, p1_ready, p2_ready;
    logic [31:0] p0_rdata, p1_rdata, p2_rdata;
    logic        m_valid;
    logic [22:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic [1:0]  grant;
    logic        timeout_err;
    logic        err_clear;

    modport slave (
        input  ram_busy, p0_valid, p1_valid, p2_valid, p0_addr, p1_addr, p2_addr,
               p0_wdata, p1_wdata, p2_wdata, p0_wstrb, p1_wstrb, p2_wstrb,
               m_ready, m_rdata, err_clear,
        output p0_ready, p1_ready, p2_ready, p0_rdata, p1_rdata, p2_rdata,
               m_valid, m_addr, m_wdata, m_wstrb, grant, timeout_err
    );
    modport master (
        output ram_busy, p0_valid, p1_valid, p2_valid, p0_addr, p1_addr, p2_addr,
               p0_wdata, p1_wdata, p2_wdata, p0_wstrb, p1_wstrb, p2_wstrb,
               m_ready, m_rdata, err_clear,
        input  p0_ready, p1_ready, p2_ready, p0_rdata, p1_rdata, p2_rdata,
               m_valid, m_addr, m_wdata, m_wstrb, grant, timeout_err
    );
endinterface

// File: rtl/iomem_arbiter.sv
// iomem_arbiter: three-port memory arbiter (p0 fixed priority, p1/p2 round-robin)
// with a registered memory port and a sticky access watchdog.
module iomem_arbiter #(
    parameter int TIMEOUT = 4096
) (
    input logic               clk,
    input logic               resetn,
    iomem_arbiter_if.slave    bus
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d, win;
    logic          last_q, last_d, m_valid_q, m_valid_d, err_q, err_d;
    logic [22:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // last_q=1 means p2 was served last, so p1 wins the next p1/p2 contention
    assign win = bus.p0_valid ? 2'd0 :
                 (bus.p1_valid && bus.p2_valid) ? (last_q ? 2'd1 : 2'd2) :
                 bus.p1_valid ? 2'd1 : bus.p2_valid ? 2'd2 : 2'd3;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        m_valid_d = m_valid_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        cnt_d     = cnt_q;
        err_d     = err_q && !bus.err_clear;
        case (state_q)
            IDLE: if (!bus.ram_busy && win != 2'd3) begin
                state_d   = BUSY;
                grant_d   = win;
                m_valid_d = 1'b1;
                cnt_d     = '0;
                last_d    = (win == 2'd0) ? last_q : (win == 2'd2);
                addr_d    = (win == 2'd0) ? bus.p0_addr  : (win == 2'd1) ? bus.p1_addr  : bus.p2_addr;
                wdata_d   = (win == 2'd0) ? bus.p0_wdata : (win == 2'd1) ? bus.p1_wdata : bus.p2_wdata;
                wstrb_d   = (win == 2'd0) ? bus.p0_wstrb : (win == 2'd1) ? bus.p1_wstrb : bus.p2_wstrb;
            end
            BUSY: begin
                cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
                if (bus.m_ready) begin
                    state_d   = IDLE;
                    m_valid_d = 1'b0;
                    grant_d   = 2'd3;
                end else if (cnt_d == LIMIT) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            grant_q   <= 2'd3;
            last_q    <= 1'b1;
            m_valid_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            m_valid_q <= m_valid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign bus.m_valid     = m_valid_q;
    assign bus.m_addr      = addr_q;
    assign bus.m_wdata     = wdata_q;
    assign bus.m_wstrb     = wstrb_q;
    assign bus.grant       = grant_q;
    assign bus.timeout_err = err_q;
    assign bus.p0_ready    = bus.m_ready && grant_q == 2'd0;
    assign bus.p1_ready    = bus.m_ready && grant_q == 2'd1;
    assign bus.p2_ready    = bus.m_ready && grant_q == 2'd2;
    assign bus.p0_rdata    = (grant_q == 2'd0) ? bus.m_rdata : 32'd0;
    assign bus.p1_rdata    = (grant_q == 2'd1) ? bus.m_rdata : 32'd0;
    assign bus.p2_rdata    = (grant_q == 2'd2) ? bus.m_rdata : 32'd0;
endmodule

// File: tb/tb_iomem_arbiter.sv
// tb_iomem_arbiter: scoreboard bench; expected grants are queued when requests are
// driven and compared when the arbiter presents them on the memory port.
module tb_iomem_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        logic [1:0]  port;
        logic [22:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;
    exp_t exp_q[$];

    iomem_arbiter_if bus ();
    iomem_arbiter #(.TIMEOUT(16)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "global timeout");
    end

    task automatic do_reset();
        resetn = 1'b0;
        {bus.ram_busy, bus.p0_valid, bus.p1_valid, bus.p2_valid, bus.m_ready, bus.err_clear} = '0;
        {bus.p0_addr, bus.p1_addr, bus.p2_addr} = '0;
        {bus.p0_wdata, bus.p1_wdata, bus.p2_wdata, bus.m_rdata} = '0;
        {bus.p0_wstrb, bus.p1_wstrb, bus.p2_wstrb} = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic req(input int p, input logic [22:0] a, input logic [31:0] d, input logic [3:0] s, input bit push);
        exp_t e;
        case (p)
            0: begin bus.p0_valid = 1'b1; bus.p0_addr = a; bus.p0_wdata = d; bus.p0_wstrb = s; end
            1: begin bus.p1_valid = 1'b1; bus.p1_addr = a; bus.p1_wdata = d; bus.p1_wstrb = s; end
            default: begin bus.p2_valid = 1'b1; bus.p2_addr = a; bus.p2_wdata = d; bus.p2_wstrb = s; end
        endcase
        e.port = 2'(p); e.addr = a; e.wdata = d; e.wstrb = s;
        if (push) exp_q.push_back(e);
    endtask

    task automatic push_exp(input int p, input logic [22:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        e.port = 2'(p); e.addr = a; e.wdata = d; e.wstrb = s;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(output int waited);
        waited = 0;
        while (bus.m_valid !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // memory model: wait for an access, pop its expectation, reply after lat cycles
    task automatic serve(input int lat, input logic [31:0] rd, input logic [2:0] drop, output int waited);
        exp_t e;
        logic [2:0] want;
        wait_valid(waited);
        tests++;
        if (bus.m_valid !== 1'b1 || exp_q.size() == 0) begin
            $display("FAIL serve_grant: m_valid=%b queued=%0d, required m_valid=1 with a queued access", bus.m_valid, exp_q.size());
            fails++;
            return;
        end
        e = exp_q.pop_front();
        if ({bus.grant, bus.m_addr, bus.m_wdata, bus.m_wstrb} !== {e.port, e.addr, e.wdata, e.wstrb}) begin
            $display("FAIL serve_fields: grant=%0d addr=%h wdata=%h wstrb=%h, required %0d %h %h %h",
                     bus.grant, bus.m_addr, bus.m_wdata, bus.m_wstrb, e.port, e.addr, e.wdata, e.wstrb);
            fails++;
        end
        repeat (lat - 1) @(negedge clk);
        tests++;
        if (bus.m_valid !== 1'b1 || bus.m_addr !== e.addr || bus.grant !== e.port) begin
            $display("FAIL serve_hold: m_valid=%b addr=%h grant=%0d, required 1 %h %0d", bus.m_valid, bus.m_addr, bus.grant, e.addr, e.port);
            fails++;
        end
        bus.m_ready = 1'b1;
        bus.m_rdata = rd;
        #1;
        want = 3'b001 << e.port;
        tests++;
        if ({bus.p2_ready, bus.p1_ready, bus.p0_ready} !== want ||
            {bus.p2_rdata, bus.p1_rdata, bus.p0_rdata} !== {want[2] ? rd : 32'd0, want[1] ? rd : 32'd0, want[0] ? rd : 32'd0}) begin
            $display("FAIL serve_ready: ready=%b rdata2=%h rdata1=%h rdata0=%h, required ready=%b data %h on port %0d only",
                     {bus.p2_ready, bus.p1_ready, bus.p0_ready}, bus.p2_rdata, bus.p1_rdata, bus.p0_rdata, want, rd, e.port);
            fails++;
        end
        @(negedge clk);
        bus.m_ready = 1'b0;
        if (drop[0]) bus.p0_valid = 1'b0;
        if (drop[1]) bus.p1_valid = 1'b0;
        if (drop[2]) bus.p2_valid = 1'b0;
        tests++;
        if (bus.m_valid !== 1'b0 || bus.grant !== 2'd3) begin
            $display("FAIL serve_release: m_valid=%b grant=%0d, required 0 3", bus.m_valid, bus.grant);
            fails++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({bus.m_valid, bus.grant, bus.m_addr, bus.m_wdata, bus.m_wstrb, bus.timeout_err} !== {1'b0, 2'd3, 23'd0, 32'd0, 4'd0, 1'b0}) begin
            $display("FAIL reset_state: m_valid=%b grant=%0d addr=%h wdata=%h wstrb=%h err=%b, required 0 3 0 0 0 0",
                     bus.m_valid, bus.grant, bus.m_addr, bus.m_wdata, bus.m_wstrb, bus.timeout_err);
            fails++;
        end
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'hFFFF_FFFF;
        #1;
        tests++;
        if ({bus.p2_ready, bus.p1_ready, bus.p0_ready} !== 3'b000 || bus.p1_rdata !== 32'd0) begin
            $display("FAIL idle_m_ready: ready=%b p1_rdata=%h, required 000 0", {bus.p2_ready, bus.p1_ready, bus.p0_ready}, bus.p1_rdata);
            fails++;
        end
        @(negedge clk);
        bus.m_ready = 1'b0;
        tests++;
        if (bus.m_valid !== 1'b0 || bus.grant !== 2'd3) begin
            $display("FAIL idle_stays: m_valid=%b grant=%0d, required 0 3", bus.m_valid, bus.grant);
            fails++;
        end
    endtask

    task automatic test_ram_busy();
        int w;
        int early = 0;
        do_reset();
        bus.ram_busy = 1'b1;
        req(1, 23'h000100, 32'h0, 4'h0, 1'b1);
        repeat (10) begin
            @(negedge clk);
            if (bus.m_valid !== 1'b0 || bus.grant !== 2'd3) early++;
        end
        tests++;
        if (early != 0) begin
            $display("FAIL ram_busy_block: %0d cycles with a grant, required 0", early);
            fails++;
        end
        bus.ram_busy = 1'b0;
        serve(2, 32'hCAFE_F00D, 3'b010, w);
        tests++;
        if (w != 1) begin
            $display("FAIL ram_busy_latency: m_valid after %0d cycles, required 1", w);
            fails++;
        end
    endtask

    task automatic test_round_robin();
        int w;
        do_reset();
        req(1, 23'h001000, 32'h1111_1111, 4'h0, 1'b0);
        req(2, 23'h002000, 32'h2222_2222, 4'hF, 1'b0);
        for (int i = 0; i < 2; i++) begin
            push_exp(1, 23'h001000, 32'h1111_1111, 4'h0);
            push_exp(2, 23'h002000, 32'h2222_2222, 4'hF);
        end
        for (int i = 0; i < 4; i++) begin
            serve(3, 32'h1234_5678, (i == 3) ? 3'b110 : 3'b000, w);
            tests++;
            if (i > 0 && w != 1) begin
                $display("FAIL rr_throughput: access %0d after %0d idle cycles, required 1", i, w);
                fails++;
            end
        end
    endtask

    task automatic test_priority();
        int w;
        do_reset();
        req(0, 23'h000040, 32'h0000_0A0A, 4'h3, 1'b0);
        req(1, 23'h000080, 32'h0000_0B0B, 4'h0, 1'b0);
        req(2, 23'h0000C0, 32'h0000_0C0C, 4'h8, 1'b0);
        repeat (4) push_exp(0, 23'h000040, 32'h0000_0A0A, 4'h3);
        push_exp(1, 23'h000080, 32'h0000_0B0B, 4'h0);
        push_exp(2, 23'h0000C0, 32'h0000_0C0C, 4'h8);
        for (int i = 0; i < 3; i++) serve(2, 32'h0000_1000 + i, 3'b000, w);
        serve(1, 32'h0000_2000, 3'b001, w);
        serve(2, 32'h0000_3000, 3'b010, w);
        serve(2, 32'h0000_4000, 3'b100, w);
    endtask

    task automatic test_timeout();
        int w;
        exp_t e;
        do_reset();
        req(2, 23'h7FFFFC, 32'hA5A5_A5A5, 4'b0101, 1'b1);
        wait_valid(w);
        tests++;
        if (bus.m_valid !== 1'b1) begin
            $display("FAIL to_grant: m_valid=%b after %0d cycles, required 1", bus.m_valid, w);
            fails++;
            return;
        end
        e = exp_q.pop_front();
        tests++;
        if ({bus.grant, bus.m_addr, bus.m_wdata, bus.m_wstrb} !== {e.port, e.addr, e.wdata, e.wstrb}) begin
            $display("FAIL to_fields: grant=%0d addr=%h wdata=%h wstrb=%h, required %0d %h %h %h",
                     bus.grant, bus.m_addr, bus.m_wdata, bus.m_wstrb, e.port, e.addr, e.wdata, e.wstrb);
            fails++;
        end
        for (int k = 1; k <= 20; k++) begin
            tests++;
            if (bus.timeout_err !== (k >= 16) || bus.m_valid !== 1'b1) begin
                $display("FAIL to_watchdog: busy cycle %0d err=%b m_valid=%b, required err=%b m_valid=1", k, bus.timeout_err, bus.m_valid, k >= 16);
                fails++;
            end
            @(negedge clk);
        end
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h0;
        #1;
        tests++;
        if (bus.p2_ready !== 1'b1) begin
            $display("FAIL to_complete: p2_ready=%b, required 1", bus.p2_ready);
            fails++;
        end
        @(negedge clk);
        bus.m_ready = 1'b0;
        bus.p2_valid = 1'b0;
        tests++;
        if (bus.m_valid !== 1'b0 || bus.timeout_err !== 1'b1) begin
            $display("FAIL to_sticky: m_valid=%b err=%b, required 0 1", bus.m_valid, bus.timeout_err);
            fails++;
        end
        bus.err_clear = 1'b1;
        @(negedge clk);
        bus.err_clear = 1'b0;
        tests++;
        if (bus.timeout_err !== 1'b0) begin
            $display("FAIL to_clear: err=%b, required 0", bus.timeout_err);
            fails++;
        end
    endtask

    task automatic test_reset_busy();
        int w;
        do_reset();
        req(1, 23'h123456, 32'hDEAD_BEEF, 4'b0011, 1'b1);
        wait_valid(w);
        void'(exp_q.pop_front());
        tests++;
        if (bus.m_valid !== 1'b1 || bus.grant !== 2'd1) begin
            $display("FAIL rb_grant: m_valid=%b grant=%0d, required 1 1", bus.m_valid, bus.grant);
            fails++;
        end
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        tests++;
        if (bus.m_valid !== 1'b0 || bus.grant !== 2'd3 || bus.m_addr !== 23'd0) begin
            $display("FAIL rb_async: m_valid=%b grant=%0d addr=%h, required 0 3 0", bus.m_valid, bus.grant, bus.m_addr);
            fails++;
        end
        bus.p1_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b1;
        #1;
        tests++;
        if ({bus.p2_ready, bus.p1_ready, bus.p0_ready} !== 3'b000) begin
            $display("FAIL rb_stray_ready: ready=%b, required 000", {bus.p2_ready, bus.p1_ready, bus.p0_ready});
            fails++;
        end
        @(negedge clk);
        bus.m_ready = 1'b0;
        tests++;
        if (bus.m_valid !== 1'b0 || bus.grant !== 2'd3) begin
            $display("FAIL rb_idle: m_valid=%b grant=%0d, required 0 3", bus.m_valid, bus.grant);
            fails++;
        end
    endtask

    task automatic test_drop_valid();
        int w;
        exp_t e;
        do_reset();
        req(2, 23'h000200, 32'h0, 4'h0, 1'b1);
        wait_valid(w);
        e = exp_q.pop_front();
        tests++;
        if (bus.m_valid !== 1'b1 || bus.grant !== e.port || bus.m_addr !== e.addr) begin
            $display("FAIL dv_grant: m_valid=%b grant=%0d addr=%h, required 1 %0d %h", bus.m_valid, bus.grant, bus.m_addr, e.port, e.addr);
            fails++;
        end
        @(negedge clk);
        bus.p2_valid = 1'b0;
        req(1, 23'h000300, 32'h3333_3333, 4'hC, 1'b1);
        repeat (2) @(negedge clk);
        tests++;
        if (bus.m_valid !== 1'b1 || bus.grant !== 2'd2) begin
            $display("FAIL dv_hold: m_valid=%b grant=%0d, required 1 2", bus.m_valid, bus.grant);
            fails++;
        end
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h0BAD_CAFE;
        #1;
        tests++;
        if (bus.p2_ready !== 1'b1 || bus.p1_ready !== 1'b0 || bus.p2_rdata !== 32'h0BAD_CAFE) begin
            $display("FAIL dv_ready: p2_ready=%b p1_ready=%b p2_rdata=%h, required 1 0 0badcafe", bus.p2_ready, bus.p1_ready, bus.p2_rdata);
            fails++;
        end
        @(negedge clk);
        bus.m_ready = 1'b0;
        serve(1, 32'h5555_AAAA, 3'b010, w);
        tests++;
        if (w != 1) begin
            $display("FAIL dv_next_grant: next m_valid after %0d cycles, required 1", w);
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_ram_busy();
        test_round_robin();
        test_priority();
        test_timeout();
        test_reset_busy();
        test_drop_valid();
        tests++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d accesses never seen, required 0", exp_q.size());
            fails++;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
